// File: rtl/acker_sample_scheduler.sv
// Per-sensor periodic sample timers feeding one ADC over a req/ack/done handshake.
// Define ACKER_ADC_TIMEOUT_EN to bound WAIT_DONE by TIMEOUT_CYCLES (error result on expiry).
module acker_sample_scheduler #(
    parameter int INTERVAL_W     = 36,
    parameter int DATA_W         = 12,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INTERVAL_W-1:0] sampling_interval,
    input  logic [1:0]            sampling_sensor,
    input  logic                  set_sampling_interval,
    output logic                  adc_req,
    output logic [1:0]            adc_channel,
    input  logic                  adc_ack,
    input  logic                  adc_done,
    input  logic [DATA_W-1:0]     adc_data,
    output logic                  sample_valid,
    output logic [1:0]            sample_sensor,
    output logic [DATA_W-1:0]     sample_data,
    output logic                  sample_error,
    output logic [3:0]            overrun
);

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT_DONE, OUTPUT} state_e;

    state_e                state_q, state_d;
    logic [INTERVAL_W-1:0] interval_q [4];
    logic [INTERVAL_W-1:0] interval_d [4];
    logic [INTERVAL_W-1:0] countdown_q [4];
    logic [INTERVAL_W-1:0] countdown_d [4];
    logic [3:0]            pending_q, pending_d;
    logic [3:0]            overrun_q, overrun_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [1:0]            chan_q, chan_d;
    logic                  adc_req_q, adc_req_d;
    logic                  sample_valid_q, sample_valid_d;
    logic [1:0]            sample_sensor_q, sample_sensor_d;
    logic [DATA_W-1:0]     sample_data_q, sample_data_d;
    logic                  ack_take;
    logic [1:0]            pick;
    logic                  pick_ok;

`ifdef ACKER_ADC_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            sample_error_q, sample_error_d;
`else
    // Without the timeout the limit has no effect.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        pick    = ptr_q;
        pick_ok = 1'b0;
        // Walk backwards so the pending sensor closest to ptr wins.
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[ptr_q + 2'(i)]) begin
                pick    = ptr_q + 2'(i);
                pick_ok = 1'b1;
            end
        end

        state_d         = state_q;
        chan_d          = chan_q;
        ptr_d           = ptr_q;
        adc_req_d       = adc_req_q;
        sample_valid_d  = 1'b0;
        sample_sensor_d = sample_sensor_q;
        sample_data_d   = sample_data_q;
        ack_take        = 1'b0;
`ifdef ACKER_ADC_TIMEOUT_EN
        wait_cnt_d      = wait_cnt_q;
        sample_error_d  = sample_error_q;
`endif

        case (state_q)
            IDLE: begin
                if (pick_ok) begin
                    chan_d    = pick;
                    adc_req_d = 1'b1;
                    state_d   = REQUEST;
                end
            end
            REQUEST: begin
                if (adc_ack) begin
                    adc_req_d = 1'b0;
                    ack_take  = 1'b1;
                    ptr_d     = chan_q + 2'd1;
                    state_d   = WAIT_DONE;
`ifdef ACKER_ADC_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end
            WAIT_DONE: begin
                if (adc_done) begin
                    sample_data_d   = adc_data;
                    sample_sensor_d = chan_q;
                    sample_valid_d  = 1'b1;
                    state_d         = OUTPUT;
`ifdef ACKER_ADC_TIMEOUT_EN
                    sample_error_d  = 1'b0;
                end else if (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    sample_data_d   = '0;
                    sample_sensor_d = chan_q;
                    sample_error_d  = 1'b1;
                    sample_valid_d  = 1'b1;
                    state_d         = OUTPUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
`endif
                end
            end
            OUTPUT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (ack_take) begin
            pending_d[chan_q] = 1'b0;
        end
        // A configuration write takes precedence over that sensor's expiry.
        for (int s = 0; s < 4; s++) begin
            interval_d[s]  = interval_q[s];
            countdown_d[s] = countdown_q[s];
            if (set_sampling_interval && (sampling_sensor == 2'(s))) begin
                interval_d[s]  = sampling_interval;
                countdown_d[s] = sampling_interval;
                overrun_d[s]   = 1'b0;
                if (sampling_interval == '0) begin
                    pending_d[s] = 1'b0;
                end
            end else if (interval_q[s] != '0) begin
                if (countdown_q[s] == INTERVAL_W'(1)) begin
                    countdown_d[s] = interval_q[s];
                    if (pending_d[s]) begin
                        overrun_d[s] = 1'b1;
                    end
                    pending_d[s] = 1'b1;
                end else begin
                    countdown_d[s] = countdown_q[s] - INTERVAL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            pending_q       <= '0;
            overrun_q       <= '0;
            ptr_q           <= '0;
            chan_q          <= '0;
            adc_req_q       <= 1'b0;
            sample_valid_q  <= 1'b0;
            sample_sensor_q <= '0;
            sample_data_q   <= '0;
            for (int s = 0; s < 4; s++) begin
                interval_q[s]  <= '0;
                countdown_q[s] <= '0;
            end
`ifdef ACKER_ADC_TIMEOUT_EN
            wait_cnt_q      <= '0;
            sample_error_q  <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            overrun_q       <= overrun_d;
            ptr_q           <= ptr_d;
            chan_q          <= chan_d;
            adc_req_q       <= adc_req_d;
            sample_valid_q  <= sample_valid_d;
            sample_sensor_q <= sample_sensor_d;
            sample_data_q   <= sample_data_d;
            interval_q      <= interval_d;
            countdown_q     <= countdown_d;
`ifdef ACKER_ADC_TIMEOUT_EN
            wait_cnt_q      <= wait_cnt_d;
            sample_error_q  <= sample_error_d;
`endif
        end
    end

    assign adc_req       = adc_req_q;
    assign adc_channel   = chan_q;
    assign sample_valid  = sample_valid_q;
    assign sample_sensor = sample_sensor_q;
    assign sample_data   = sample_data_q;
    assign overrun       = overrun_q;
`ifdef ACKER_ADC_TIMEOUT_EN
    assign sample_error  = sample_error_q;
`else
    assign sample_error  = 1'b0;
`endif

endmodule

// File: tb/tb_acker_sample_scheduler.sv
// Directed bench for acker_sample_scheduler with a behavioural ADC responder.
module tb_acker_sample_scheduler;

    logic        clock;
    logic        reset;
    logic [35:0] sampling_interval;
    logic [1:0]  sampling_sensor;
    logic        set_sampling_interval;
    logic        adc_req;
    logic [1:0]  adc_channel;
    logic        adc_ack;
    logic        adc_done;
    logic [11:0] adc_data;
    logic        sample_valid;
    logic [1:0]  sample_sensor;
    logic [11:0] sample_data;
    logic        sample_error;
    logic [3:0]  overrun;

    int          n_checks = 0;
    int          n_fail   = 0;

    int          ack_delay  = 0;
    int          done_delay = 0;
    bit          done_on    = 1'b1;
    bit          model_busy = 1'b0;
    int          mcnt       = 0;
    logic [11:0] model_last_data = '0;

    typedef struct {
        logic [1:0] s;
        int         ival;
        int         a;
        int         d;
        int         first;
        int         period;
    } vec_t;

    vec_t        vt [4];
    logic [1:0]  ord2 [6];
    int          tv [3];
    int          nv, nreq, tfirst, last;
    logic        errv;
    logic [11:0] datav;

    acker_sample_scheduler #(
        .INTERVAL_W    (36),
        .DATA_W        (12),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .sampling_interval    (sampling_interval),
        .sampling_sensor      (sampling_sensor),
        .set_sampling_interval(set_sampling_interval),
        .adc_req              (adc_req),
        .adc_channel          (adc_channel),
        .adc_ack              (adc_ack),
        .adc_done             (adc_done),
        .adc_data             (adc_data),
        .sample_valid         (sample_valid),
        .sample_sensor        (sample_sensor),
        .sample_data          (sample_data),
        .sample_error         (sample_error),
        .overrun              (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_sampling_interval = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 100 && model_busy; i++) tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input logic [1:0] s, input int iv);
        sampling_sensor       = s;
        sampling_interval     = 36'(iv);
        set_sampling_interval = 1'b1;
        tick();
        set_sampling_interval = 1'b0;
    endtask

    // ADC responder: ack after ack_delay cycles, done done_delay cycles after the ack.
    initial begin : adc_model
        adc_ack  = 1'b0;
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            tick();
            if (adc_req === 1'b1) begin
                model_busy = 1'b1;
                for (int k = 0; k < ack_delay; k++) tick();
                adc_ack = 1'b1;
                tick();
                adc_ack = 1'b0;
                if (done_on) begin
                    for (int k = 0; k < done_delay; k++) tick();
                    model_last_data = 12'h3C5 + 12'(mcnt * 29);
                    mcnt++;
                    adc_data = model_last_data;
                    adc_done = 1'b1;
                    tick();
                    adc_done = 1'b0;
                    adc_data = ~model_last_data;
                end
                model_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: time limit reached, actual running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        reset                 = 1'b1;
        sampling_interval     = '0;
        sampling_sensor       = '0;
        set_sampling_interval = 1'b0;

        vt[0] = '{2'd2, 5, 0, 1, 9, 5};
        vt[1] = '{2'd0, 4, 0, 0, 7, 4};
        vt[2] = '{2'd3, 10, 2, 3, 18, 10};
        vt[3] = '{2'd1, 7, 1, 2, 13, 7};
        ord2  = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

        do_reset();
        chk("rst_adc_req", adc_req, 0);
        chk("rst_adc_channel", adc_channel, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_sample_sensor", sample_sensor, 0);
        chk("rst_sample_data", sample_data, 0);
        chk("rst_sample_error", sample_error, 0);
        chk("rst_overrun", overrun, 0);

        // Single-sensor periodic runs: first strobe latency and steady period.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            ack_delay  = vt[r].a;
            done_delay = vt[r].d;
            done_on    = 1'b1;
            load(vt[r].s, vt[r].ival);
            nv = 0;
            for (int c = 1; c <= 8 * vt[r].ival + 40 && nv < 3; c++) begin
                tick();
                if (sample_valid) begin
                    tv[nv] = c;
                    chk($sformatf("vec%0d_sensor", r), sample_sensor, vt[r].s);
                    chk($sformatf("vec%0d_data", r), sample_data, model_last_data);
                    chk($sformatf("vec%0d_error", r), sample_error, 0);
                    nv++;
                end
            end
            chk($sformatf("vec%0d_count", r), nv, 3);
            if (nv == 3) begin
                chk($sformatf("vec%0d_first", r), tv[0], vt[r].first);
                chk($sformatf("vec%0d_gap1", r), tv[1] - tv[0], vt[r].period);
                chk($sformatf("vec%0d_gap2", r), tv[2] - tv[1], vt[r].period);
            end
            chk($sformatf("vec%0d_overrun", r), overrun, 0);
        end

        // Three sensors contend: round-robin order 0,1,3 and strobe spacing.
        do_reset();
        ack_delay  = 10;
        done_delay = 0;
        done_on    = 1'b1;
        sampling_interval     = 36'd20;
        sampling_sensor       = 2'd0;
        set_sampling_interval = 1'b1;
        tick();
        sampling_sensor = 2'd1;
        tick();
        sampling_sensor = 2'd3;
        tick();
        set_sampling_interval = 1'b0;
        nv   = 0;
        last = 0;
        for (int c = 1; c <= 400 && nv < 6; c++) begin
            tick();
            if (sample_valid) begin
                chk($sformatf("rr_order%0d", nv), sample_sensor, ord2[nv]);
                if (nv > 0) chk($sformatf("rr_spacing%0d", nv), (c - last) >= 4, 1);
                last = c;
                nv++;
            end
        end
        chk("rr_count", nv, 6);

        // Withheld ack causes a sticky overrun; a new set clears it.
        do_reset();
        ack_delay  = 12;
        done_delay = 0;
        load(2'd1, 4);
        nv     = 0;
        tfirst = 0;
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (c == 10) chk("ovr_set", overrun, 4'b0010);
            if (sample_valid) begin
                nv++;
                tfirst = c;
                chk("ovr_sensor", sample_sensor, 1);
            end
        end
        chk("ovr_conv_count", nv, 1);
        chk("ovr_conv_time", tfirst, 19);
        chk("ovr_sticky", overrun, 4'b0010);
        load(2'd1, 0);
        chk("ovr_cleared", overrun, 0);
        nv   = 0;
        nreq = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (sample_valid) nv++;
            if (adc_req) nreq++;
        end
        chk("ovr_disabled_valids", nv, 0);
        chk("ovr_disabled_reqs", nreq, 0);

        // Disable a sensor while its request is outstanding.
        do_reset();
        ack_delay  = 3;
        done_delay = 0;
        load(2'd0, 8);
        for (int c = 1; c <= 9; c++) tick();
        chk("dis_req_raised", adc_req, 1);
        chk("dis_channel", adc_channel, 0);
        load(2'd0, 0);
        chk("dis_req_held", adc_req, 1);
        nv     = 0;
        nreq   = 0;
        tfirst = 0;
        for (int c = 11; c <= 60; c++) begin
            tick();
            if (sample_valid) begin
                nv++;
                tfirst = c;
                chk("dis_sensor", sample_sensor, 0);
            end
            if (c > 15 && adc_req) nreq++;
        end
        chk("dis_valid_count", nv, 1);
        chk("dis_valid_time", tfirst, 14);
        chk("dis_later_reqs", nreq, 0);

        // Reset during WAIT_DONE; the late adc_done must be ignored.
        do_reset();
        ack_delay  = 0;
        done_delay = 5;
        done_on    = 1'b1;
        load(2'd2, 6);
        for (int c = 1; c <= 10; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rwd_adc_req", adc_req, 0);
        chk("rwd_adc_channel", adc_channel, 0);
        chk("rwd_sample_valid", sample_valid, 0);
        chk("rwd_sample_data", sample_data, 0);
        chk("rwd_overrun", overrun, 0);
        nv   = 0;
        nreq = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (sample_valid) nv++;
            if (adc_req) nreq++;
        end
        chk("rwd_valids", nv, 0);
        chk("rwd_reqs", nreq, 0);

        // ADC never completes.
        do_reset();
        ack_delay = 0;
        done_on   = 1'b0;
        load(2'd3, 5);
        nv     = 0;
        tfirst = 0;
        errv   = 1'b0;
        datav  = '1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (sample_valid) begin
                nv++;
                if (nv == 1) begin
                    tfirst = c;
                    errv   = sample_error;
                    datav  = sample_data;
                end
            end
        end
`ifdef ACKER_ADC_TIMEOUT_EN
        chk("to_valid_count", nv, 3);
        chk("to_first_time", tfirst, 57);
        chk("to_error", errv, 1);
        chk("to_data", datav, 0);
`else
        chk("to_valid_count", nv, 0);
        chk("to_req_low", adc_req, 0);
`endif
        chk("to_overrun", overrun, 4'b1000);
        done_on = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acker_sample_scheduler.md
Name: acker_sample_scheduler

Overview:
Downstream consumer of the order controller's sampling-configuration outputs (sampling_interval, sampling_sensor, set_sampling_interval).
- Keeps one programmable periodic timer per soil sensor.
- Queues expired sensors.
- Issues one conversion at a time to the ADC front end over a req/ack/done handshake.
- Presents each captured result as a one-cycle sample strobe for the logging/RS232 Tx path.

Parameters:
INTERVAL_W, 36, width of interval register and per-sensor countdown
DATA_W, 12, ADC result width
TIMEOUT_CYCLES, 100000, WAIT_DONE limit (only used with ACKER_ADC_TIMEOUT_EN)

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-high
sampling_interval  in  INTERVAL_W  new period in clock cycles; 0 disables the sensor
sampling_sensor  in  2  sensor index 0..3 for sampling_interval
set_sampling_interval  in  1  one-cycle load strobe
adc_req  out  1  conversion request; held until acknowledged
adc_channel  out  2  sensor being converted; stable while adc_req or WAIT_DONE
adc_ack  in  1  ADC accepted the request
adc_done  in  1  conversion finished; adc_data valid this cycle
adc_data  in  DATA_W  conversion result
sample_valid  out  1  one-cycle result strobe
sample_sensor  out  2  sensor of the result
sample_data  out  DATA_W  result
sample_error  out  1  result invalid (timeout); qualified by sample_valid
overrun  out  4  sticky per-sensor flag: period expired while that sensor was still pending

Behaviour:
Reset (synchronous, active-high, any state):
- All outputs 0.
- All intervals 0, all sensors disabled.
- Countdowns 0, pending 0.
- Round-robin pointer 0, FSM in IDLE.
- An in-flight conversion is abandoned; a later adc_done is ignored in IDLE.

Configuration (set_sampling_interval=1, sensor s):
- interval[s] <= sampling_interval; countdown[s] <= sampling_interval; overrun[s] <= 0.
- If sampling_interval==0: sensor disabled and pending[s] cleared. An in-flight conversion of s still completes and is output.
- Set wins over an expiry of s in the same cycle: no pending is raised.

Timers:
- Enabled sensor (interval!=0): countdown decrements each cycle.
- When countdown==1: reload with interval and set pending[s].
- Period is exactly interval cycles. First expiry occurs interval cycles after the load edge.
- If pending[s] is already 1 at expiry: overrun[s] <= 1 and pending stays 1 (requests do not queue deeper).

FSM (IDLE, REQUEST, WAIT_DONE, OUTPUT):
- IDLE: if any pending, choose the first pending sensor in round-robin order starting at ptr. Latch it into adc_channel, set adc_req=1, go to REQUEST. Otherwise stay in IDLE.
- REQUEST: hold adc_req until adc_ack=1 is sampled. On that edge:
  - adc_req <= 0
  - pending[chan] <= 0 (a later expiry re-raises it without overrun)
  - ptr <= chan+1 (mod 4)
  - go to WAIT_DONE
- WAIT_DONE: on adc_done=1:
  - sample_data <= adc_data, sample_sensor <= chan, sample_error <= 0
  - go to OUTPUT
- OUTPUT: sample_valid=1 for exactly this cycle; next state IDLE.

Latency:
- Pending set at edge N gives adc_req=1 after edge N+1.
- adc_done sampled at edge M gives sample_valid=1 in the cycle after edge M.

Other rules:
- adc_ack and adc_done are sampled only in their own state and ignored elsewhere.
- adc_ack and adc_done high together in REQUEST: the ack is taken; the done is ignored.
- Minimum back-to-back spacing between sample_valid strobes is 4 cycles.
- Countdown arithmetic is unsigned INTERVAL_W. A maximum interval of 2^INTERVAL_W−1 is legal.

Optional Feature:
ACKER_ADC_TIMEOUT_EN
- Defined:
  - A WAIT_DONE cycle counter is cleared on entry.
  - If TIMEOUT_CYCLES elapse with no adc_done, go to OUTPUT with sample_error=1 and sample_data=0.
  - adc_done in the same cycle as the timeout takes priority, giving a normal result.
- Undefined:
  - No counter; WAIT_DONE waits indefinitely.
  - sample_error is constant 0.

Test Plan:
1. Reset, set sensor 2 interval=5; ADC model acks 1 cycle after req and dones 3 cycles later -> adc_channel=2, sample_valid every 5 cycles, sample_sensor=2, sample_data=model value, overrun=0.
2. Sensors 0,1,3 all set to interval=20 on consecutive cycles; ack delayed 10 cycles -> conversions served in order 0,1,3 then wrap; no sensor starved; sample_valid strobes ≥4 cycles apart.
3. Sensor 1 interval=4, ack withheld 12 cycles -> overrun[1]=1 sticky; exactly one conversion for sensor 1 after ack; a new set on sensor 1 clears overrun[1].
4. Sensor 0 running at interval=8; set sensor 0 interval=0 while pending and not yet acked -> pending cleared, adc_req drops never having been acked? No: adc_req already high stays until ack, then result is output; afterwards no further requests for sensor 0.
5. Assert reset in WAIT_DONE, then pulse adc_done -> all outputs 0, no sample_valid, FSM IDLE.
6. With ACKER_ADC_TIMEOUT_EN and TIMEOUT_CYCLES=50, ADC never dones -> sample_valid with sample_error=1, sample_data=0, 50 cycles after entering WAIT_DONE; without the macro -> no sample_valid.
